// File: rtl/dds_pkg.sv
// Shared constants and helpers for the DDS waveform generator.
// Mode encodings, output width derivation and parameter legality.
package dds_pkg;

    localparam logic [1:0] MODE_SINE   = 2'b00;
    localparam logic [1:0] MODE_TRI    = 2'b01;
    localparam logic [1:0] MODE_SQUARE = 2'b10;
    localparam logic [1:0] MODE_SAW    = 2'b11;

    localparam real DDS_PI = 3.14159265358979323846;

    // Output carries one extra bit above the quarter-wave magnitude.
    function automatic int dds_out_w(input int amp_w);
        return amp_w + 1;
    endfunction

    function automatic bit dds_params_ok(
        input int phase_w,
        input int addr_w,
        input int amp_w
    );
        return (addr_w >= 1) &&
               (addr_w <= amp_w) &&
               (amp_w <= 2 * addr_w) &&
               (phase_w >= addr_w + 2);
    endfunction

endpackage

// File: rtl/dds_quarter_rom.sv
// Registered quarter-wave sine table, one cycle read latency.
// Contents are generated at elaboration from the sine formula.
module dds_quarter_rom
    import dds_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int AMP_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [AMP_W-1:0]  data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    // rom[i] = floor(2^AMP_W * sin(pi/2 * i / DEPTH)), packed LSB-first.
    function automatic logic [DEPTH*AMP_W-1:0] gen_table();
        logic [DEPTH*AMP_W-1:0] t;
        real                    x;
        int                     v;
        t = '0;
        for (int i = 0; i < DEPTH; i++) begin
            x = (2.0 ** AMP_W) *
                $sin(DDS_PI / 2.0 * real'(i) / real'(DEPTH));
            v = $rtoi(x);
            t[i*AMP_W +: AMP_W] = AMP_W'(v);
        end
        return t;
    endfunction

    localparam logic [DEPTH*AMP_W-1:0] TABLE = gen_table();

    logic [AMP_W-1:0] data_q;
    logic [AMP_W-1:0] data_d;

    // Table lookup for the addressed entry.
    always_comb begin
        data_d = TABLE[int'(addr_i)*AMP_W +: AMP_W];
    end

    // Output register gives the one-cycle read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, folded quarter-wave
// lookup and a three-stage sine/triangle/square/saw output pipeline.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 6,
    parameter int AMP_W   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_load,
    input  logic               cfg_clr,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_word,
    input  logic [1:0]         mode_sel,
    output logic [AMP_W:0]     dout,
    output logic               dout_valid,
    output logic               cycle_pulse
);

    localparam int OUT_W = dds_out_w(AMP_W);
    localparam logic [OUT_W-1:0] MID = {1'b1, {AMP_W{1'b0}}};
    localparam logic [OUT_W-1:0] FULL = '1;
    localparam logic [ADDR_W-1:0] IDX_MAX = '1;

    if (!dds_params_ok(PHASE_W, ADDR_W, AMP_W)) begin : g_bad_params
        $error("dds_wave_gen: illegal PHASE_W/ADDR_W/AMP_W combination");
    end

    // Accumulator and configuration state.
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [1:0]         mode_q, mode_d;
    logic [PHASE_W:0]   acc_sum;

    // Stage 1: phase split.
    logic [PHASE_W-1:0] ph;
    logic               ph_unused;
    logic [OUT_W-1:0]   saw_bits;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_wrap_q, s1_wrap_d;
    logic [1:0]         s1_quad_q, s1_quad_d;
    logic [ADDR_W-1:0]  s1_idx_q, s1_idx_d;
    logic [1:0]         s1_mode_q, s1_mode_d;
    logic [OUT_W-1:0]   s1_saw_q, s1_saw_d;

    // Stage 2: fold and ROM read.
    logic [ADDR_W-1:0]  idx_f;
    logic [AMP_W-1:0]   rom_mag;
    logic               s2_valid_q, s2_valid_d;
    logic               s2_wrap_q, s2_wrap_d;
    logic [1:0]         s2_quad_q, s2_quad_d;
    logic [ADDR_W-1:0]  s2_idx_q, s2_idx_d;
    logic [1:0]         s2_mode_q, s2_mode_d;
    logic [OUT_W-1:0]   s2_saw_q, s2_saw_d;

    // Stage 3: compose output.
    logic [AMP_W-1:0]   tri_mag;
    logic [AMP_W-1:0]   mag;
    logic [OUT_W-1:0]   wave;
    logic [OUT_W-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               pulse_q, pulse_d;

    assign acc_sum = {1'b0, acc_q} + {1'b0, freq_q};

    // Next accumulator/config; clear wins over the increment.
    always_comb begin
        acc_d   = acc_q;
        wrap_d  = wrap_q;
        freq_d  = freq_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        if (en) begin
            acc_d  = acc_sum[PHASE_W-1:0];
            wrap_d = acc_sum[PHASE_W];
        end
        if (cfg_load) begin
            freq_d  = freq_word;
            phase_d = phase_word;
            mode_d  = mode_sel;
            if (cfg_clr) begin
                acc_d  = '0;
                wrap_d = 1'b0;
            end
        end
    end

    // Accumulator and configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            wrap_q  <= 1'b0;
            freq_q  <= '0;
            phase_q <= '0;
            mode_q  <= MODE_SINE;
        end else begin
            acc_q   <= acc_d;
            wrap_q  <= wrap_d;
            freq_q  <= freq_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
        end
    end

    assign ph        = acc_q + phase_q;
    assign ph_unused = ^ph;

    if (PHASE_W >= OUT_W) begin : g_saw_slice
        assign saw_bits = ph[PHASE_W-1 -: OUT_W];
    end else begin : g_saw_pad
        assign saw_bits = {ph, {(OUT_W-PHASE_W){1'b0}}};
    end

    // Stage 1: offset phase, split into quadrant and table index.
    always_comb begin
        s1_valid_d = en;
        s1_wrap_d  = wrap_q;
        s1_quad_d  = ph[PHASE_W-1 -: 2];
        s1_idx_d   = ph[PHASE_W-3 -: ADDR_W];
        s1_mode_d  = mode_q;
        s1_saw_d   = saw_bits;
    end

    // Stage 1 registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_wrap_q  <= 1'b0;
            s1_quad_q  <= '0;
            s1_idx_q   <= '0;
            s1_mode_q  <= MODE_SINE;
            s1_saw_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_wrap_q  <= s1_wrap_d;
            s1_quad_q  <= s1_quad_d;
            s1_idx_q   <= s1_idx_d;
            s1_mode_q  <= s1_mode_d;
            s1_saw_q   <= s1_saw_d;
        end
    end

    // Odd quadrants run the table backwards.
    assign idx_f = s1_quad_q[0] ? (IDX_MAX - s1_idx_q) : s1_idx_q;

    dds_quarter_rom #(
        .ADDR_W (ADDR_W),
        .AMP_W  (AMP_W)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_i (idx_f),
        .data_o (rom_mag)
    );

    // Stage 2: carry sample tags alongside the ROM read.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_wrap_d  = s1_wrap_q;
        s2_quad_d  = s1_quad_q;
        s2_idx_d   = idx_f;
        s2_mode_d  = s1_mode_q;
        s2_saw_d   = s1_saw_q;
    end

    // Stage 2 registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_wrap_q  <= 1'b0;
            s2_quad_q  <= '0;
            s2_idx_q   <= '0;
            s2_mode_q  <= MODE_SINE;
            s2_saw_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_wrap_q  <= s2_wrap_d;
            s2_quad_q  <= s2_quad_d;
            s2_idx_q   <= s2_idx_d;
            s2_mode_q  <= s2_mode_d;
            s2_saw_q   <= s2_saw_d;
        end
    end

    // Triangle magnitude replicates the index MSBs into the low bits.
    if (AMP_W == ADDR_W) begin : g_tri_eq
        assign tri_mag = s2_idx_q;
    end else begin : g_tri_ext
        assign tri_mag = {s2_idx_q, s2_idx_q[ADDR_W-1 -: AMP_W-ADDR_W]};
    end

    // Stage 3: per-mode magnitude and offset-binary composition.
    always_comb begin
        mag  = '0;
        wave = MID;
        case (s2_mode_q)
            MODE_SINE: mag = rom_mag;
            MODE_TRI:  mag = tri_mag;
            default:   mag = '0;
        endcase
        case (s2_mode_q)
            MODE_SINE, MODE_TRI: begin
                wave = s2_quad_q[1] ? (MID - {1'b0, mag})
                                    : (MID + {1'b0, mag});
            end
            MODE_SQUARE: wave = s2_quad_q[1] ? '0 : FULL;
            default:     wave = s2_saw_q;
        endcase
        dout_d  = s2_valid_q ? wave : dout_q;
        valid_d = s2_valid_q;
        pulse_d = s2_valid_q & s2_wrap_q;
    end

    // Output registers; dout holds across invalid slots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q  <= MID;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = valid_q;
    assign cycle_pulse = pulse_q;

endmodule
